// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I memory-access stage: funct3 encodings,
// FSM state type, MEM/WB register layout and wait-counter sizing.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic        reg_write;
        logic        result_src;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic        fault;
    } wb_t;

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'b0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'b0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: data-memory request/ready handshake with timeout, store
// formatting, load alignment and the MEM/WB pipeline register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RegWriteM,
    input  logic        ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic        FaultW
);

    localparam int CW = cnt_width(WAIT_LIMIT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    wb_t           wb_q, wb_d;

    logic        access, legal_f3, misaligned, bad_access, go;
    logic        req, stall, complete, abort, fault_w;
    logic [31:0] ld_data;

    assign access = ResultSrcM | MemWriteM;

    always_comb begin
        if (MemWriteM) legal_f3 = Funct3M inside {F3_B, F3_H, F3_W};
        else           legal_f3 = Funct3M inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        misaligned = (Funct3M[1:0] == 2'b01 && ALUResultM[0]) ||
                     (Funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00);
    end

    assign bad_access = access & (~legal_f3 | misaligned);
    assign go         = access & ~bad_access;

    // Store lanes; loads always read the full word.
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = WriteDataM;
        if (MemWriteM) begin
            case (Funct3M[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << ALUResultM[1:0];
                    dmem_wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    dmem_be    = 4'b0011 << ALUResultM[1:0];
                    dmem_wdata = {2{WriteDataM[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign dmem_addr = {ALUResultM[31:2], 2'b00};
    assign dmem_we   = MemWriteM;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    req = 1'b1;
                    if (dmem_ready) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dmem_ready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == CW'(WAIT_LIMIT)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Reset must drop the bus request without waiting for a clock edge.
    assign dmem_req = req & RST_N;
    assign StallM   = stall & RST_N;

    load_align u_align (
        .rdata_i  (dmem_rdata),
        .addr_i   (ALUResultM[1:0]),
        .funct3_i (Funct3M),
        .data_o   (ld_data)
    );

    assign fault_w = ((state_q == IDLE) & bad_access) | abort;

    // Stall cycles load an all-zero bubble so W never sees a partial access.
    always_comb begin
        wb_d = '0;
        if (!stall) begin
            wb_d.reg_write  = RegWriteM & ~fault_w;
            wb_d.result_src = ResultSrcM;
            wb_d.alu_result = ALUResultM;
            wb_d.read_data  = (complete & ResultSrcM) ? ld_data : 32'b0;
            wb_d.rd         = RdM;
            wb_d.pc_plus4   = PCPlus4M;
            wb_d.fault      = fault_w;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

    assign RegWriteW  = wb_q.reg_write;
    assign ResultSrcW = wb_q.result_src;
    assign ALUResultW = wb_q.alu_result;
    assign ReadDataW  = wb_q.read_data;
    assign RdW        = wb_q.rd;
    assign PCPlus4W   = wb_q.pc_plus4;
    assign FaultW     = wb_q.fault;

endmodule
